// File: rtl/xadc_wb_scanner_pkg.sv
// Shared constants for the XADC Wishbone scanner: DRP addresses, scan order,
// FSM encoding and channel index width.
package xadc_wb_scanner_pkg;

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned NUM_CH = 4;

    localparam logic [7:0] XADC_ADR_TEMP   = 8'h80;
    localparam logic [7:0] XADC_ADR_VCCINT = 8'h81;
    localparam logic [7:0] XADC_ADR_VCCAUX = 8'h82;
    localparam logic [7:0] XADC_ADR_VBRAM  = 8'h86;

    // Entry i is polled at channel index i
    localparam logic [NUM_CH-1:0][7:0] SCAN_LIST = {
        XADC_ADR_VBRAM, XADC_ADR_VCCAUX, XADC_ADR_VCCINT, XADC_ADR_TEMP
    };

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_REQ_ENC  = 2'd2;
    localparam logic [1:0] ST_GAP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_REQ  = ST_REQ_ENC,
        ST_GAP  = ST_GAP_ENC
    } state_t;

endpackage

// File: rtl/xadc_wb_scanner_if.sv
// Wishbone classic-cycle bus between the scanner (master) and the XADC responder.
interface xadc_wb_scanner_if #(
    parameter int unsigned aw = 8,
    parameter int unsigned dw = 16
) ();
    logic [aw-1:0] wbm_adr_o;
    logic [dw-1:0] wbm_dat_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_we_o;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic [2:0]    wbm_cti_o;
    logic [1:0]    wbm_bte_o;
    logic [dw-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;
    logic          wbm_rty_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
               wbm_cti_o, wbm_bte_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
    );
endinterface

// File: rtl/xadc_wb_scanner_cnt.sv
// Loadable down-counter that stops at zero and flags it.
module xadc_wb_scanner_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         wb_clk_i,
    input  logic         async_rst_i,
    input  logic         wb_rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);
    logic [W-1:0] cnt_q;

    // Load has priority over decrement; the count parks at zero
    always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            cnt_q <= '0;
        end else if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/xadc_wb_scanner.sv
// Autonomous Wishbone initiator that polls XADC temp/VCCINT/VCCAUX/VBRAM via the
// DRP window and caches the 12-bit results. Optional temperature alarm with
// hysteresis is built when XADC_WB_SCANNER_TEMP_ALARM_EN is defined.
module xadc_wb_scanner
    import xadc_wb_scanner_pkg::*;
#(
    parameter int unsigned dw      = 16,
    parameter int unsigned aw      = 8,
    parameter int unsigned PERIOD  = 100000,
    parameter int unsigned TIMEOUT = 255
`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
    ,
    parameter logic [11:0] TEMP_HI = 12'hB00,
    parameter logic [11:0] TEMP_LO = 12'hA80
`endif
) (
    input  logic        wb_clk_i,
    input  logic        async_rst_i,
    input  logic        wb_rst_i,
    input  logic        enable_i,
    input  logic        start_i,
    xadc_wb_scanner_if.master wbm,
    output logic [11:0] temp_o,
    output logic [11:0] vccint_o,
    output logic [11:0] vccaux_o,
    output logic [11:0] vbram_o,
    output logic [3:0]  valid_o,
    output logic        scan_done_o,
    output logic        busy_o,
    output logic [7:0]  err_cnt_o
`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
    ,
    output logic        temp_alarm_o
`endif
);
    localparam int unsigned PER_W = $clog2(PERIOD);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       cyc_q, cyc_d;
    logic                       done_q, done_d;
    logic                       busy_q;
    logic [aw-1:0]              adr_q;
    logic [NUM_CH-1:0][11:0]    slot_q;
    logic [NUM_CH-1:0]          valid_q;
    logic [7:0]                 err_cnt_q;

    logic req_c, ok_c, fail_c;
    logic per_load_c, per_dec_c, per_zero_c, to_zero_c;
    logic unused_dat_c;

    // The DRP data sits in the upper 12 bits; the low nibble is never used
    assign unused_dat_c = ^wbm.wbm_dat_i[3:0];

    // Error beats ack; ack beats a timeout expiring in the same cycle
    assign req_c  = (state_q == ST_REQ);
    assign ok_c   = req_c & wbm.wbm_ack_i & ~wbm.wbm_err_i & ~wbm.wbm_rty_i;
    assign fail_c = req_c & (wbm.wbm_err_i | wbm.wbm_rty_i | (to_zero_c & ~wbm.wbm_ack_i));

    xadc_wb_scanner_cnt #(.W(PER_W)) u_period (
        .wb_clk_i    (wb_clk_i),
        .async_rst_i (async_rst_i),
        .wb_rst_i    (wb_rst_i),
        .load        (per_load_c),
        .load_val    (PER_W'(PERIOD - 1)),
        .dec         (per_dec_c),
        .zero_c      (per_zero_c)
    );

    // Reloaded in every non-REQ cycle so each transaction starts a fresh budget
    xadc_wb_scanner_cnt #(.W(TO_W)) u_timeout (
        .wb_clk_i    (wb_clk_i),
        .async_rst_i (async_rst_i),
        .wb_rst_i    (wb_rst_i),
        .load        (~req_c),
        .load_val    (TO_W'(TIMEOUT - 1)),
        .dec         (req_c),
        .zero_c      (to_zero_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cyc_d      = 1'b0;
        done_d     = 1'b0;
        per_load_c = 1'b0;
        per_dec_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i || start_i) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                    cyc_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (per_zero_c || start_i) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                    cyc_d   = 1'b1;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    per_dec_c = 1'b1;
                end
            end
            ST_REQ: begin
                if (ok_c || fail_c) begin
                    state_d = ST_GAP;
                end else begin
                    cyc_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (idx_q != IDX_W'(NUM_CH - 1)) begin
                    state_d = ST_REQ;
                    idx_d   = idx_q + IDX_W'(1);
                    cyc_d   = 1'b1;
                end else begin
                    state_d    = ST_WAIT;
                    done_d     = 1'b1;
                    per_load_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered bus/status outputs
    always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (wb_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            adr_q   <= cyc_d ? aw'(SCAN_LIST[idx_d]) : '0;
            done_q  <= done_d;
            busy_q  <= (state_d == ST_REQ) || (state_d == ST_GAP);
        end
    end

    // Result cache: ack updates the slot, failure only invalidates it
    always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            slot_q    <= '0;
            valid_q   <= '0;
            err_cnt_q <= '0;
        end else if (wb_rst_i) begin
            slot_q    <= '0;
            valid_q   <= '0;
            err_cnt_q <= '0;
        end else if (ok_c) begin
            slot_q[idx_q]  <= wbm.wbm_dat_i[15:4];
            valid_q[idx_q] <= 1'b1;
        end else if (fail_c) begin
            valid_q[idx_q] <= 1'b0;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
    // Hysteretic over-temperature flag, evaluated only on fresh temp captures
    always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            temp_alarm_o <= 1'b0;
        end else if (wb_rst_i) begin
            temp_alarm_o <= 1'b0;
        end else if (ok_c && (idx_q == '0)) begin
            if (wbm.wbm_dat_i[15:4] > TEMP_HI) begin
                temp_alarm_o <= 1'b1;
            end else if (wbm.wbm_dat_i[15:4] < TEMP_LO) begin
                temp_alarm_o <= 1'b0;
            end
        end
    end
`endif

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dw'(0);
    assign wbm.wbm_sel_o = 4'b0011;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_cti_o = 3'b000;
    assign wbm.wbm_bte_o = 2'b00;

    assign temp_o      = slot_q[0];
    assign vccint_o    = slot_q[1];
    assign vccaux_o    = slot_q[2];
    assign vbram_o     = slot_q[3];
    assign valid_o     = valid_q;
    assign scan_done_o = done_q;
    assign busy_o      = busy_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_xadc_wb_scanner.sv
// Self-checking bench for xadc_wb_scanner: a scripted XADC responder plus a
// scoreboard of expected per-transaction outcomes.
module tb_xadc_wb_scanner;

    localparam logic [1:0] M_ACK     = 2'd0;
    localparam logic [1:0] M_ERR_ACK = 2'd1;
    localparam logic [1:0] M_NONE    = 2'd2;
    localparam logic [1:0] M_RTY     = 2'd3;
    localparam int         TO_CYC    = 8;

    typedef struct {
        int         ch;
        logic [7:0] adr;
        int         len;
        logic       ok;
        logic [11:0] val;
        logic [7:0] errs;
    } exp_t;

    logic        wb_clk_i;
    logic        async_rst_i;
    logic        wb_rst_i;
    logic        enable_i;
    logic        start_i;
    logic [11:0] temp_o, vccint_o, vccaux_o, vbram_o;
    logic [3:0]  valid_o;
    logic        scan_done_o;
    logic        busy_o;
    logic [7:0]  err_cnt_o;
`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
    logic        temp_alarm_o;
`endif

    xadc_wb_scanner_if #(.aw(8), .dw(16)) wbm ();

    xadc_wb_scanner #(.dw(16), .aw(8), .PERIOD(16), .TIMEOUT(TO_CYC)) dut (
        .wb_clk_i    (wb_clk_i),
        .async_rst_i (async_rst_i),
        .wb_rst_i    (wb_rst_i),
        .enable_i    (enable_i),
        .start_i     (start_i),
        .wbm         (wbm),
        .temp_o      (temp_o),
        .vccint_o    (vccint_o),
        .vccaux_o    (vccaux_o),
        .vbram_o     (vbram_o),
        .valid_o     (valid_o),
        .scan_done_o (scan_done_o),
        .busy_o      (busy_o),
        .err_cnt_o   (err_cnt_o)
`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
        , .temp_alarm_o (temp_alarm_o)
`endif
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Responder script and bench-side model
    logic [3:0][1:0]  mode;
    logic [3:0][15:0] sdata;
    logic [3:0][7:0]  adrs = {8'h86, 8'h82, 8'h81, 8'h80};
    logic [3:0][11:0] m_val;
    logic [3:0]       m_valid;
    logic [7:0]       m_errs;
    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic [1:0] ch_of(input logic [7:0] a);
        case (a)
            8'h81:   return 2'd1;
            8'h82:   return 2'd2;
            8'h86:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [1:0] sch;
    logic       ssel;
    assign sch  = ch_of(wbm.wbm_adr_o);
    assign ssel = wbm.wbm_cyc_o & wbm.wbm_stb_o;
    assign wbm.wbm_ack_i = ssel & ((mode[sch] == M_ACK) | (mode[sch] == M_ERR_ACK));
    assign wbm.wbm_err_i = ssel & (mode[sch] == M_ERR_ACK);
    assign wbm.wbm_rty_i = ssel & (mode[sch] == M_RTY);
    assign wbm.wbm_dat_i = ssel ? sdata[sch] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] slot_out(input int ch);
        case (ch)
            0:       return temp_o;
            1:       return vccint_o;
            2:       return vccaux_o;
            default: return vbram_o;
        endcase
    endfunction

    // Script one channel's response and queue the outcome the scanner must show
    task automatic plan(input int ch, input logic [1:0] m, input logic [15:0] d);
        exp_t x;
        mode[ch]  = m;
        sdata[ch] = d;
        if (m == M_ACK) begin
            m_val[ch]   = d[15:4];
            m_valid[ch] = 1'b1;
            x.len       = 1;
        end else begin
            m_valid[ch] = 1'b0;
            if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
            x.len = (m == M_NONE) ? TO_CYC : 1;
        end
        x.ch   = ch;
        x.adr  = adrs[ch];
        x.ok   = (m == M_ACK);
        x.val  = m_val[ch];
        x.errs = m_errs;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!scan_done_o && n < budget);
        check("scan_done_seen", scan_done_o, 1'b1);
        check("busy_after_scan", busy_o, 1'b0);
    endtask

    task automatic wait_stb(input int budget);
        int n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!wbm.wbm_stb_o && n < budget);
        check("stb_seen", wbm.wbm_stb_o, 1'b1);
        check("busy_in_txn", busy_o, 1'b1);
    endtask

    task automatic idle_window(input string tag);
        int hits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge wb_clk_i);
            if (wbm.wbm_stb_o || wbm.wbm_cyc_o) hits++;
        end
        check(tag, hits, 0);
        check("busy_idle", busy_o, 1'b0);
    endtask

    task automatic start_scan(input logic [15:0] d0, d1, d2, d3);
        plan(0, M_ACK, d0);
        plan(1, M_ACK, d1);
        plan(2, M_ACK, d2);
        plan(3, M_ACK, d3);
        @(negedge wb_clk_i);
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        wait_done(200);
    endtask

    // Transaction monitor: pops the scoreboard when each strobe drops
    logic       mon_prev;
    int         mon_len, mon_low;
    logic [7:0] mon_adr;
    always @(negedge wb_clk_i) begin
        exp_t e;
        if (async_rst_i) begin
            mon_prev = 1'b0;
            mon_len  = 0;
            mon_low  = 0;
        end else begin
            if (wbm.wbm_stb_o) begin
                if (!mon_prev) begin
                    mon_adr = wbm.wbm_adr_o;
                    mon_len = 0;
                    if (mon_adr != 8'h80) check("gap_cycles", mon_low, 1);
                end
                mon_len++;
            end else if (mon_prev) begin
                mon_low = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", mon_adr, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_adr", mon_adr, e.adr);
                    check("stb_len", mon_len, e.len);
                    check("cyc_dropped", wbm.wbm_cyc_o, 1'b0);
                    check("valid_bit", valid_o[e.ch], e.ok);
                    check("slot_value", slot_out(e.ch), e.val);
                    check("err_cnt", err_cnt_o, e.errs);
                end
            end else begin
                mon_low++;
            end
            mon_prev = wbm.wbm_stb_o;
        end
    end

    initial begin
        int k;
        async_rst_i = 1'b1;
        wb_rst_i    = 1'b0;
        enable_i    = 1'b0;
        start_i     = 1'b0;
        mode        = '0;
        sdata       = '0;
        m_val       = '0;
        m_valid     = '0;
        m_errs      = '0;
        repeat (2) @(negedge wb_clk_i);

        check("rst_cyc", wbm.wbm_cyc_o, 1'b0);
        check("rst_stb", wbm.wbm_stb_o, 1'b0);
        check("rst_adr", wbm.wbm_adr_o, 8'h00);
        check("rst_valid", valid_o, 4'h0);
        check("rst_err_cnt", err_cnt_o, 8'h00);
        check("rst_temp", temp_o, 12'h000);
        check("rst_done", scan_done_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("const_sel", wbm.wbm_sel_o, 4'b0011);
        check("const_we", wbm.wbm_we_o, 1'b0);
`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
        check("rst_alarm", temp_alarm_o, 1'b0);
`endif
        async_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Scan 1: every channel acks
        plan(0, M_ACK, 16'hA5C0);
        plan(1, M_ACK, 16'h5550);
        plan(2, M_ACK, 16'h9990);
        plan(3, M_ACK, 16'h5560);
        enable_i = 1'b1;
        wait_done(200);
        check("s1_temp", temp_o, 12'hA5C);
        check("s1_vccint", vccint_o, 12'h555);
        check("s1_vccaux", vccaux_o, 12'h999);
        check("s1_vbram", vbram_o, 12'h556);
        check("s1_valid", valid_o, 4'hF);

        // Scan 2: err together with ack on VCCINT; also time the restart
        plan(0, M_ACK, 16'hB000);
        plan(1, M_ERR_ACK, 16'h1230);
        plan(2, M_ACK, 16'h9990);
        plan(3, M_ACK, 16'h5560);
        k = 0;
        do begin
            @(negedge wb_clk_i);
            k++;
            if (k == 1) check("done_one_cycle", scan_done_o, 1'b0);
        end while (!wbm.wbm_stb_o && k < 64);
        check("scan_period", k, 16);
        wait_done(200);
        check("s2_valid", valid_o, 4'b1101);
        check("s2_vccint_kept", vccint_o, 12'h555);
        check("s2_err_cnt", err_cnt_o, 8'd1);

        // Scan 3: VCCAUX never answers, VBRAM retries; enable drops mid-scan
        plan(0, M_ACK, 16'h3210);
        plan(1, M_ACK, 16'h7770);
        plan(2, M_NONE, 16'h0000);
        plan(3, M_RTY, 16'h0000);
        wait_stb(64);
        enable_i = 1'b0;
        wait_done(200);
        check("s3_valid", valid_o, 4'b0011);
        check("s3_err_cnt", err_cnt_o, 8'd3);
        check("s3_vccaux_kept", vccaux_o, 12'h999);
        check("s3_vbram_kept", vbram_o, 12'h556);
        idle_window("s3_stays_idle");

        // Asynchronous reset while strobing the temperature address
        mode[0]  = M_NONE;
        enable_i = 1'b1;
        wait_stb(16);
        check("rst_mid_adr", wbm.wbm_adr_o, 8'h80);
        #1 async_rst_i = 1'b1;
        #1;
        check("arst_cyc", wbm.wbm_cyc_o, 1'b0);
        check("arst_stb", wbm.wbm_stb_o, 1'b0);
        check("arst_valid", valid_o, 4'h0);
        check("arst_err_cnt", err_cnt_o, 8'h00);
        check("arst_vccint", vccint_o, 12'h000);
        enable_i = 1'b0;
        m_val    = '0;
        m_valid  = '0;
        m_errs   = '0;
        @(negedge wb_clk_i);
        #1 async_rst_i = 1'b0;

        // One start-triggered scan with enable low, then the scanner rests
        start_scan(16'h1110, 16'h2220, 16'h3330, 16'h4440);
        check("s4_valid", valid_o, 4'hF);
        check("s4_vbram", vbram_o, 12'h444);
        idle_window("s4_stays_idle");

`ifdef XADC_WB_SCANNER_TEMP_ALARM_EN
        start_scan(16'hB010, 16'h2220, 16'h3330, 16'h4440);
        check("alarm_set", temp_alarm_o, 1'b1);
        start_scan(16'hAA00, 16'h2220, 16'h3330, 16'h4440);
        check("alarm_hold", temp_alarm_o, 1'b1);
        start_scan(16'hA7F0, 16'h2220, 16'h3330, 16'h4440);
        check("alarm_clear", temp_alarm_o, 1'b0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xadc_wb_scanner.md
Name: xadc_wb_scanner

Overview:
- Wishbone classic-cycle initiator that autonomously polls the XADC status registers through the XADC Wishbone responder's DRP window (address bit 7 = 1).
- Caches the latest 12-bit temperature, VCCINT, VCCAUX and VBRAM conversions for use by fabric logic such as fan control and thermal throttling.
- Sits beside the CPU on the Wishbone arbiter, as a second master into the XADC slave.

Parameters:
- dw, 16, Wishbone data width
- aw, 8, Wishbone address width
- PERIOD, 100000, wb_clk_i cycles between scan starts (minimum 16)
- TIMEOUT, 255, cycles to wait for ack/err before abandoning a transaction (minimum 4)
- TEMP_HI, 12'hB00, alarm assert threshold (optional feature only)
- TEMP_LO, 12'hA80, alarm deassert threshold (optional feature only)

Ports:
- wb_clk_i  in  1  clock
- async_rst_i  in  1  asynchronous active-high reset
- wb_rst_i  in  1  synchronous active-high reset
- enable_i  in  1  level; 1 = periodic scanning enabled
- start_i  in  1  pulse; forces an immediate scan when idle
- wbm_adr_o  out  aw  Wishbone address
- wbm_dat_o  out  dw  write data, constant 0
- wbm_sel_o  out  4  constant 4'b0011
- wbm_we_o  out  1  constant 0
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_cti_o  out  3  constant 3'b000
- wbm_bte_o  out  2  constant 2'b00
- wbm_dat_i  in  dw  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry, treated as err
- temp_o, vccint_o, vccaux_o, vbram_o  out  12 each  cached wbm_dat_i[15:4]
- valid_o  out  4  per-channel valid {vbram, vccaux, vccint, temp}
- scan_done_o  out  1  one-cycle pulse at end of each scan
- busy_o  out  1  high in any state other than IDLE/WAIT
- err_cnt_o  out  8  saturating count of failed transactions

Behaviour:
- Reset (async_rst_i or wb_rst_i) clears the following to 0: all outputs, the period counter, the channel index, and err_cnt_o. State goes to IDLE.
- Asynchronous reset mid-transaction drops cyc/stb immediately.
- Fixed scan list, index 0..3: 0x80 temp, 0x81 vccint, 0x82 vccaux, 0x86 vbram.
- States: IDLE, WAIT, REQ, GAP.
  - IDLE: enable_i=1 or start_i=1 → REQ with index 0.
  - WAIT: period counter decrements.
    - Reaches 0, or start_i=1 → REQ with index 0.
    - enable_i=0 → IDLE.
  - REQ: cyc=stb=1, adr=list[index]; timeout counter runs.
    - ack: capture dat_i[15:4] into the slot; set valid bit; drop cyc/stb on the next edge; → GAP.
    - err, rty, or timeout expiry: drop cyc/stb; increment err_cnt_o (saturates at 255); clear the slot's valid bit; slot value unchanged; → GAP.
    - ack and err in the same cycle: err wins.
  - GAP: exactly one idle cycle with cyc=stb=0. This is mandatory because the slave edge-detects its DRP enable.
    - index<3 → index+1, REQ.
    - index==3 → pulse scan_done_o, reload counter with PERIOD-1, → WAIT.
- Latency: stb is asserted on the cycle after the transition into REQ; captured data is visible on the cycle after ack.
- start_i while in REQ/GAP is ignored.
- enable_i falling mid-scan: the current scan completes, then → IDLE.
- Minimum scan with single-cycle acks: 4×(1 REQ + 1 GAP) = 8 cycles.

Optional Feature:
- Macro XADC_WB_SCANNER_TEMP_ALARM_EN.
- When defined, adds output temp_alarm_o (1 bit, reset 0):
  - Sets when a new temp capture > TEMP_HI.
  - Clears when a new temp capture < TEMP_LO.
  - Otherwise holds; updates only on a valid temp capture.
- When undefined: no port, no comparator logic, and TEMP_HI/TEMP_LO are unused.

Decomposition:
- Package xadc_wb_scanner_pkg contains:
  - the DRP address constants (XADC_ADR_TEMP=8'h80, VCCINT=8'h81, VCCAUX=8'h82, VBRAM=8'h86)
  - the 4-entry scan list
  - the state encoding localparams
  - the channel index width (2)
- Sub-module xadc_wb_scanner_cnt: loadable down-counter with zero flag. It is instantiated twice, once for the period and once for the timeout.

Test Plan:
- enable_i=1, PERIOD=16, slave acks reads 0x80/81/82/86 with 16'hA5C0/16'h5550/16'h9990/16'h5560:
  - temp_o=12'hA5C, vccint_o=12'h555, vccaux_o=12'h999, vbram_o=12'h556, valid_o=4'hF
  - scan_done_o pulses once; the next scan starts 16 cycles later.
- Slave asserts err on 0x81:
  - err_cnt_o=1, valid_o[1]=0, vccint_o keeps its prior value
  - the scan continues to 0x82 after exactly one GAP cycle.
- Slave never responds on 0x82, TIMEOUT=8: cyc drops after 8 cycles of stb, err_cnt_o increments, and the scan moves to 0x86.
- Slave acks every read: check stb is low for exactly 1 cycle between consecutive transactions.
- async_rst_i pulse while stb=1 on 0x80: cyc/stb/outputs are 0 within the same cycle; after release, with enable_i=0 and start_i pulsed, one full scan runs and then the scanner stays IDLE.
- With XADC_WB_SCANNER_TEMP_ALARM_EN, successive temp captures of 12'hB01, 12'hAA0 and 12'hA7F give temp_alarm_o = 1, 1, 0.
